instr_loader: RTL and testbench
===============================

INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, instruction buffer entries; power of two, at least 4, shall be supported.
REQ-002 Parameter CNT_W, default 16, width of the loaded-word counter, shall be supported.
REQ-003 Ports, one per line: name  direction  width  meaning.
- t_clk  in  1  clock, rising edge.
- t_rst  in  1  reset, asynchronous, active-low.
- l_i_start  in  1  one-cycle pulse that begins a program load.
- l_o_syn  out  1  request to the upstream transmitter, registered.
- l_i_instr  in  IWIDTH  upstream instruction word.
- l_i_ack  in  1  l_i_instr is valid this cycle.
- l_i_last  in  1  final word of the program; qualified by l_i_ack.
- l_i_rd_en  in  1  fetch-side pop request.
- l_o_instr  out  IWIDTH  head of buffer, show-ahead.
- l_o_valid  out  1  buffer non-empty.
- l_o_full  out  1  buffer full.
- l_o_busy  out  1  load in progress.
- l_o_done  out  1  last word captured; held until next start.
- l_o_count  out  CNT_W  words captured in the current load.
- l_o_ovf  out  1  sticky overflow flag.

Function
REQ-004 The block shall implement FSM states IDLE, LOAD and DONE.
REQ-005 IDLE shall go to LOAD on l_i_start; DONE shall go to LOAD on l_i_start; l_i_start in LOAD shall be ignored.
REQ-006 Entering LOAD shall clear l_o_count and l_o_done; buffer contents shall be kept.
REQ-007 In LOAD, l_o_syn next value shall be 1 exactly when occupancy after this cycle's write and pop is at most FIFO_DEPTH-2; this credit covers the one word in flight caused by the transmitter's one-cycle response latency.
REQ-008 The block shall capture l_i_instr into the buffer on every cycle with l_i_ack=1 in LOAD, and increment l_o_count, which saturates at all-ones.
REQ-009 A captured word with l_i_last=1 shall move LOAD to DONE, and l_o_syn shall be 0 from the next edge.
REQ-010 l_i_ack in IDLE or DONE shall be dropped: no write, no count change.
REQ-011 A capture while full shall be dropped and set l_o_ovf; l_o_ovf shall clear only on reset.
REQ-012 A pop shall occur when l_i_rd_en=1 and l_o_valid=1; l_i_rd_en with an empty buffer shall be ignored.
REQ-013 A simultaneous write and pop shall be legal at any occupancy, including full (no overflow) and empty (l_o_valid rises next cycle, no bypass).
REQ-014 Read and write pointers shall wrap modulo FIFO_DEPTH; occupancy shall be tracked with a pointer width one bit wider than the address.
REQ-015 l_o_busy shall equal (state==LOAD); l_o_done shall equal (state==DONE).
REQ-016 Write-to-l_o_valid latency shall be 1 cycle; start-to-l_o_syn latency shall be 1 cycle.

Reset
REQ-017 Asserting t_rst at any time, including mid-load, shall force IDLE and an empty buffer, with every output 0 except l_o_instr.
REQ-018 l_o_instr shall read 0 while the buffer is empty.
REQ-019 Buffer storage shall not require reset.

Configuration
REQ-020 With LOADER_CHECKSUM_EN defined, the block shall add output l_o_csum (IWIDTH): an XOR of all words captured in the current load, cleared on entering LOAD and on reset, and frozen in DONE.
REQ-021 Without LOADER_CHECKSUM_EN, the l_o_csum port and its logic shall be absent.

Structure
REQ-022 IWIDTH and the FSM state encodings shall come from the shared header; FIFO_DEPTH and CNT_W shall stay local parameters.
REQ-023 The buffer shall be a sub-module named instr_fifo, with write and read ports, full, empty and show-ahead data; instr_loader shall contain the FSM, the credit logic and the counters.

Verification
V1: Connect to the transmitter with a 5-word program (0x20080001..0x20080005); start pulse, no pops -> l_o_count=5, l_o_done=1, FIFO holds 5 in order, l_o_syn=0.
V2: 12-word program, FIFO_DEPTH=8, no pops until done stalls -> l_o_syn drops at occupancy 7, l_o_ovf stays 0; then pop continuously -> syn resumes, all 12 words are read in order, done=1.
V3: Full FIFO with a write and pop in the same cycle -> occupancy stays 8, l_o_ovf=0, head advances one word.
V4: Forced l_i_ack=1 while full (syn ignored) -> l_o_ovf=1 and stays 1, count unchanged.
V5: Reset asserted mid-load after 3 words -> next cycle state is IDLE, l_o_valid=0, l_o_count=0, l_o_syn=0; a new start reloads correctly.
V6: LOADER_CHECKSUM_EN defined, words 0x0000000F, 0x000000F0, 0x00000F00 -> l_o_csum=0x00000FFF in DONE.

Source files
------------

// File: rtl/instr_loader_pkg.sv
// Shared definitions for the instruction loader: word width and FSM encoding.
package instr_loader_pkg;

  localparam int IWIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } ld_state_e;

endpackage

// File: rtl/instr_loader_if.sv
// Loader bus: upstream transmitter handshake, fetch-side pop port and status.
// Optional checksum output is present only when LOADER_CHECKSUM_EN is defined.
interface instr_loader_if #(
  parameter int CNT_W = 16
);
  import instr_loader_pkg::*;

  logic              l_i_start;
  logic              l_o_syn;
  logic [IWIDTH-1:0] l_i_instr;
  logic              l_i_ack;
  logic              l_i_last;
  logic              l_i_rd_en;
  logic [IWIDTH-1:0] l_o_instr;
  logic              l_o_valid;
  logic              l_o_full;
  logic              l_o_busy;
  logic              l_o_done;
  logic [CNT_W-1:0]  l_o_count;
  logic              l_o_ovf;
`ifdef LOADER_CHECKSUM_EN
  logic [IWIDTH-1:0] l_o_csum;
`endif

  // Driver side: transmitter + fetch unit (bench or surrounding logic).
  modport master (
    output l_i_start, l_i_instr, l_i_ack, l_i_last, l_i_rd_en,
`ifdef LOADER_CHECKSUM_EN
    input  l_o_csum,
`endif
    input  l_o_syn, l_o_instr, l_o_valid, l_o_full, l_o_busy, l_o_done,
           l_o_count, l_o_ovf
  );

  // Loader side.
  modport slave (
    input  l_i_start, l_i_instr, l_i_ack, l_i_last, l_i_rd_en,
`ifdef LOADER_CHECKSUM_EN
    output l_o_csum,
`endif
    output l_o_syn, l_o_instr, l_o_valid, l_o_full, l_o_busy, l_o_done,
           l_o_count, l_o_ovf
  );

endinterface

// File: rtl/instr_loader_fifo.sv
// instr_fifo: show-ahead instruction buffer. Pointers carry one extra bit so
// full and empty are distinguishable; storage itself is not reset.
module instr_fifo
  import instr_loader_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int W     = IWIDTH
) (
  input  logic                     t_clk,
  input  logic                     t_rst,
  input  logic                     wr_en,
  input  logic [W-1:0]             wr_data,
  input  logic                     rd_en,
  output logic [W-1:0]             rd_data,
  output logic                     wr_ack,
  output logic                     rd_ack,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   occ
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_P = (AW+1)'(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr, rptr;

  assign occ   = wptr - rptr;
  assign full  = (occ == DEPTH_P);
  assign empty = (wptr == rptr);

  // A pop in the same cycle frees the slot, so a write at full still lands.
  assign rd_ack = rd_en && !empty;
  assign wr_ack = wr_en && (!full || rd_ack);

  // Empty buffer reads as zero rather than stale storage.
  assign rd_data = empty ? '0 : mem[rptr[AW-1:0]];

  // Storage write, no reset needed.
  always_ff @(posedge t_clk) begin
    if (wr_ack) mem[wptr[AW-1:0]] <= wr_data;
  end

  // Pointer update, wrapping naturally on the extra-bit counter.
  always_ff @(posedge t_clk or negedge t_rst) begin
    if (!t_rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_ack) wptr <= wptr + 1'b1;
      if (rd_ack) rptr <= rptr + 1'b1;
    end
  end

endmodule

// File: rtl/instr_loader.sv
// instr_loader: pulls a program from an upstream transmitter into a buffer
// using a registered request (l_o_syn) with one word of credit for the
// transmitter's response latency. Optional feature macro: LOADER_CHECKSUM_EN
// adds a running XOR of the words captured in the current load.
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 16
) (
  input logic          t_clk,
  input logic          t_rst,
  instr_loader_if.slave bus
);

  localparam int          AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] SYN_MAX = (AW+1)'(FIFO_DEPTH-2);

  ld_state_e         state;
  logic              syn;
  logic              ovf;
  logic [CNT_W-1:0]  count;
  logic              wr_req, wr_ack, rd_ack, full, empty;
  logic [AW:0]       occ, occ_nxt;
  logic [IWIDTH-1:0] head;
`ifdef LOADER_CHECKSUM_EN
  logic [IWIDTH-1:0] csum;
`endif

  // Words offered outside LOAD are dropped before reaching the buffer.
  assign wr_req  = (state == LOAD) && bus.l_i_ack;
  assign occ_nxt = occ + {{AW{1'b0}}, wr_ack} - {{AW{1'b0}}, rd_ack};

  instr_fifo #(.DEPTH(FIFO_DEPTH), .W(IWIDTH)) u_fifo (
    .t_clk   (t_clk),
    .t_rst   (t_rst),
    .wr_en   (wr_req),
    .wr_data (bus.l_i_instr),
    .rd_en   (bus.l_i_rd_en),
    .rd_data (head),
    .wr_ack  (wr_ack),
    .rd_ack  (rd_ack),
    .full    (full),
    .empty   (empty),
    .occ     (occ)
  );

  // Load FSM with registered request, counter, overflow and checksum.
  always_ff @(posedge t_clk or negedge t_rst) begin
    if (!t_rst) begin
      state <= IDLE;
      syn   <= 1'b0;
      count <= '0;
      ovf   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum  <= '0;
`endif
    end else begin
      if (wr_req && !wr_ack) ovf <= 1'b1;
      unique case (state)
        IDLE, DONE: begin
          if (bus.l_i_start) begin
            state <= LOAD;
            count <= '0;
            syn   <= (occ_nxt <= SYN_MAX);
`ifdef LOADER_CHECKSUM_EN
            csum  <= '0;
`endif
          end else begin
            syn <= 1'b0;
          end
        end
        LOAD: begin
          if (wr_ack) begin
            if (count != '1) count <= count + CNT_W'(1);
`ifdef LOADER_CHECKSUM_EN
            csum <= csum ^ bus.l_i_instr;
`endif
          end
          if (wr_ack && bus.l_i_last) begin
            state <= DONE;
            syn   <= 1'b0;
          end else begin
            syn <= (occ_nxt <= SYN_MAX);
          end
        end
        default: begin
          state <= IDLE;
          syn   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.l_o_syn   = syn;
  assign bus.l_o_instr = head;
  assign bus.l_o_valid = !empty;
  assign bus.l_o_full  = full;
  assign bus.l_o_busy  = (state == LOAD);
  assign bus.l_o_done  = (state == DONE);
  assign bus.l_o_count = count;
  assign bus.l_o_ovf   = ovf;
`ifdef LOADER_CHECKSUM_EN
  assign bus.l_o_csum  = csum;
`endif

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader with a one-cycle-latency transmitter model.
module tb_instr_loader;
  import instr_loader_pkg::*;

  localparam int DEPTH = 8;
  localparam int CW    = 16;

  logic t_clk = 1'b0;
  logic t_rst = 1'b0;
  always #5 t_clk = ~t_clk;

  instr_loader_if #(.CNT_W(CW)) bus ();

  instr_loader #(.FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .t_clk (t_clk),
    .t_rst (t_rst),
    .bus   (bus.slave)
  );

  int nvec = 0;
  int nerr = 0;
  logic [IWIDTH-1:0] prog [16];
  int plen, tx_idx, rd_idx;
  bit tx_on, saw_syn;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: transmitter answers next cycle for a request seen this cycle.
  task automatic step(input logic start, input logic rd);
    logic s;
    bus.l_i_start = start;
    bus.l_i_rd_en = rd;
    s = bus.l_o_syn;
    @(posedge t_clk);
    #1;
    bus.l_i_start = 1'b0;
    bus.l_i_rd_en = 1'b0;
    if (tx_on && s && tx_idx < plen) begin
      bus.l_i_ack   = 1'b1;
      bus.l_i_instr = prog[tx_idx];
      bus.l_i_last  = (tx_idx == plen - 1);
      tx_idx++;
    end else begin
      bus.l_i_ack  = 1'b0;
      bus.l_i_last = 1'b0;
    end
  endtask

  task automatic load_prog(input logic [IWIDTH-1:0] base, input int n);
    for (int i = 0; i < n; i++) prog[i] = base + IWIDTH'(i);
    plen = n; tx_idx = 0; rd_idx = 0; tx_on = 1'b1;
  endtask

  // Pop until n words read, checking order; a bound expiry shows in the _all check.
  task automatic drain(input string tag, input int n);
    for (int i = 0; i < 4 * n + 20 && rd_idx < n; i++) begin
      if (bus.l_o_syn) saw_syn = 1'b1;
      if (bus.l_o_valid) begin
        chk(tag, bus.l_o_instr, prog[rd_idx]);
        rd_idx++;
        step(1'b0, 1'b1);
      end else begin
        step(1'b0, 1'b0);
      end
    end
    chk({tag, "_all"}, rd_idx, n);
  endtask

  task automatic do_reset();
    t_rst = 1'b0;
    bus.l_i_ack = 1'b0; bus.l_i_last = 1'b0;
    tx_idx = 0;
    @(posedge t_clk); #1;
    t_rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.l_i_start = 1'b0; bus.l_i_instr = '0; bus.l_i_ack = 1'b0;
    bus.l_i_last = 1'b0; bus.l_i_rd_en = 1'b0;
    tx_on = 1'b0; plen = 0; tx_idx = 0; rd_idx = 0; saw_syn = 1'b0;

    // Reset state
    repeat (2) @(posedge t_clk);
    #1;
    chk("rst_syn",   bus.l_o_syn,   0);
    chk("rst_valid", bus.l_o_valid, 0);
    chk("rst_full",  bus.l_o_full,  0);
    chk("rst_busy",  bus.l_o_busy,  0);
    chk("rst_done",  bus.l_o_done,  0);
    chk("rst_count", bus.l_o_count, 0);
    chk("rst_ovf",   bus.l_o_ovf,   0);
    chk("rst_instr", bus.l_o_instr, 0);
    t_rst = 1'b1;
    step(1'b0, 1'b0);

    // V1: 5-word program, no pops; a second start mid-load is ignored
    load_prog(32'h2008_0001, 5);
    step(1'b1, 1'b0);
    chk("v1_syn_lat", bus.l_o_syn, 1);
    chk("v1_busy", bus.l_o_busy, 1);
    repeat (3) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    repeat (8) step(1'b0, 1'b0);
    chk("v1_count", bus.l_o_count, 5);
    chk("v1_done",  bus.l_o_done,  1);
    chk("v1_busy0", bus.l_o_busy,  0);
    chk("v1_syn",   bus.l_o_syn,   0);
    chk("v1_valid", bus.l_o_valid, 1);
    drain("v1_data", 5);
    step(1'b0, 1'b1);
    chk("v1_empty_pop_valid", bus.l_o_valid, 0);
    chk("v1_empty_instr", bus.l_o_instr, 0);

    // V2: 12-word program stalls at full, then drains with syn resuming
    load_prog(32'h3000_0000, 12);
    step(1'b1, 1'b0);
    repeat (20) step(1'b0, 1'b0);
    chk("v2_full",  bus.l_o_full,  1);
    chk("v2_count", bus.l_o_count, 8);
    chk("v2_syn",   bus.l_o_syn,   0);
    chk("v2_ovf",   bus.l_o_ovf,   0);
    chk("v2_busy",  bus.l_o_busy,  1);
    saw_syn = 1'b0;
    drain("v2_data", 12);
    chk("v2_syn_resumed", saw_syn, 1);
    chk("v2_done",  bus.l_o_done,  1);
    chk("v2_count12", bus.l_o_count, 12);
    chk("v2_ovf_end", bus.l_o_ovf, 0);

    // V3: write and pop together at full
    load_prog(32'h4000_0000, 12);
    step(1'b1, 1'b0);
    repeat (20) step(1'b0, 1'b0);
    chk("v3_full_pre", bus.l_o_full, 1);
    chk("v3_head_pre", bus.l_o_instr, 32'h4000_0000);
    tx_on = 1'b0;
    bus.l_i_ack = 1'b1; bus.l_i_instr = 32'hDEAD_0001; bus.l_i_last = 1'b0;
    step(1'b0, 1'b1);
    chk("v3_full",  bus.l_o_full,  1);
    chk("v3_ovf",   bus.l_o_ovf,   0);
    chk("v3_count", bus.l_o_count, 9);
    chk("v3_head",  bus.l_o_instr, 32'h4000_0001);

    // V4: forced write while full overflows, sticky
    bus.l_i_ack = 1'b1; bus.l_i_instr = 32'hBAD0_0002; bus.l_i_last = 1'b0;
    step(1'b0, 1'b0);
    chk("v4_ovf",   bus.l_o_ovf,   1);
    chk("v4_count", bus.l_o_count, 9);
    chk("v4_head",  bus.l_o_instr, 32'h4000_0001);
    repeat (3) step(1'b0, 1'b0);
    chk("v4_ovf_sticky", bus.l_o_ovf, 1);

    // V5: reset after 3 words, then a clean reload
    do_reset();
    chk("v5_ovf_clr", bus.l_o_ovf, 0);
    load_prog(32'h5000_0000, 12);
    step(1'b1, 1'b0);
    for (int i = 0; i < 20 && bus.l_o_count != 3; i++) step(1'b0, 1'b0);
    chk("v5_count3", bus.l_o_count, 3);
    t_rst = 1'b0;
    bus.l_i_ack = 1'b0; bus.l_i_last = 1'b0;
    #1;
    chk("v5_async_busy",  bus.l_o_busy,  0);
    chk("v5_async_valid", bus.l_o_valid, 0);
    chk("v5_async_count", bus.l_o_count, 0);
    chk("v5_async_syn",   bus.l_o_syn,   0);
    @(posedge t_clk); #1;
    chk("v5_idle_busy", bus.l_o_busy, 0);
    chk("v5_idle_done", bus.l_o_done, 0);
    chk("v5_idle_instr", bus.l_o_instr, 0);
    t_rst = 1'b1;
    load_prog(32'h6000_0000, 5);
    step(1'b1, 1'b0);
    repeat (12) step(1'b0, 1'b0);
    chk("v5_count", bus.l_o_count, 5);
    chk("v5_done",  bus.l_o_done,  1);
    drain("v5_data", 5);

`ifdef LOADER_CHECKSUM_EN
    // V6: checksum over three nibble-lane words
    do_reset();
    chk("v6_csum_rst", bus.l_o_csum, 0);
    prog[0] = 32'h0000_000F; prog[1] = 32'h0000_00F0; prog[2] = 32'h0000_0F00;
    plen = 3; tx_idx = 0; rd_idx = 0; tx_on = 1'b1;
    step(1'b1, 1'b0);
    repeat (10) step(1'b0, 1'b0);
    chk("v6_done", bus.l_o_done, 1);
    chk("v6_csum", bus.l_o_csum, 32'h0000_0FFF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
